// File: rtl/spi_master_tx.sv
// Mode-0 SPI master: one WIDTH-bit word per CS_N frame, MSB first, start/busy/done handshake.
// Optional back-to-back bursting with CS_N held low is enabled by defining SPI_MASTER_BURST_EN.
module spi_master_tx #(
  parameter int WIDTH    = 32,
  parameter int DIV      = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             CS_N,
  output logic             SCK,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int MAX_A   = (DIV > CS_SETUP) ? DIV : CS_SETUP;
  localparam int MAX_CNT = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
  localparam int DW      = $clog2(MAX_CNT + 1);
  localparam int BW      = $clog2(WIDTH);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [DW-1:0] SETUP_LAST = DW'(CS_SETUP - 1);
  localparam logic [DW-1:0] IDLE_LAST  = DW'(CS_IDLE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic             div_last;
  logic             bit_last;
  logic             burst_take;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    div_last = 1'b0;
    case (state)
      SETUP:           div_last = (div_cnt == SETUP_LAST);
      LOW, HIGH, HOLD: div_last = (div_cnt == DIV_LAST);
      GAP:             div_last = (div_cnt == IDLE_LAST);
      default:         div_last = 1'b0;
    endcase
  end

  assign bit_last = (bit_cnt == BIT_LAST);

`ifdef SPI_MASTER_BURST_EN
  assign burst_take = (state == HOLD) && div_last && start;
`else
  assign burst_take = 1'b0;
`endif

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start)    state_nxt = SETUP;
      SETUP: if (div_last) state_nxt = LOW;
      LOW:   if (div_last) state_nxt = HIGH;
      HIGH:  if (div_last) state_nxt = bit_last ? HOLD : LOW;
      HOLD:  if (div_last) state_nxt = burst_take ? LOW : GAP;
      GAP:   if (div_last) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Every timed state leaves on div_last, so the counter restarts from zero on each entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || div_last) div_cnt <= '0;
      else                           div_cnt <= div_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            bit_cnt  <= '0;
          end
        end
        LOW: begin
          // MISO is captured on the edge that raises SCK.
          if (div_last) rx_shift <= {rx_shift[WIDTH-2:0], MISO};
        end
        HIGH: begin
          if (div_last && !bit_last) begin
            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_last) begin
            rx_data <= rx_shift;
            done    <= 1'b1;
            if (burst_take) begin
              tx_shift <= tx_data;
              bit_cnt  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pin outputs decode straight from state so reset takes effect on the same edge.
  always_comb begin
    CS_N = 1'b1;
    SCK  = 1'b0;
    MOSI = 1'b0;
    busy = (state != IDLE);
    case (state)
      SETUP, LOW, HOLD: begin
        CS_N = 1'b0;
        MOSI = tx_shift[WIDTH-1];
      end
      HIGH: begin
        CS_N = 1'b0;
        SCK  = 1'b1;
        MOSI = tx_shift[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: table of loopback/tied-MISO frames plus reset, held-start,
// end-of-frame start (burst when SPI_MASTER_BURST_EN is defined) and a DIV=1 8-bit slave exchange.
module tb_spi_master_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] tx_data;
  logic        busy, done, cs_n, sck, mosi, miso;
  logic [31:0] rx_data;
  logic [1:0]  miso_mode;

  logic       start8;
  logic [7:0] tx8;
  logic       busy8, done8, cs8, sck8, mosi8, miso8;
  logic [7:0] rx8;
  logic [7:0] slave_tx, slave_rx;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1);

  spi_master_tx #(.WIDTH(32), .DIV(2), .CS_SETUP(2), .CS_IDLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
    .rx_data(rx_data), .CS_N(cs_n), .SCK(sck), .MOSI(mosi), .MISO(miso)
  );

  spi_master_tx #(.WIDTH(8), .DIV(1), .CS_SETUP(2), .CS_IDLE(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .busy(busy8), .done(done8),
    .rx_data(rx8), .CS_N(cs8), .SCK(sck8), .MOSI(mosi8), .MISO(miso8)
  );

  // Mode-0 slave: loads 0x3C while deselected, shifts out on SCK fall, captures on SCK rise.
  assign miso8 = slave_tx[7];
  always @(negedge sck8 or posedge cs8) begin
    if (cs8) slave_tx <= 8'h3C;
    else     slave_tx <= {slave_tx[6:0], 1'b0};
  end
  always @(posedge sck8) slave_rx <= {slave_rx[6:0], mosi8};

  typedef struct {
    logic [31:0] tx;
    logic [1:0]  mode;   // 0 loopback, 1 MISO tied high, 2 MISO tied low
    logic [31:0] rx;
    int          ones;   // samples with MOSI high during the frame
  } vec_t;

`ifdef SPI_MASTER_BURST_EN
  localparam int EXP_HOLD_DONES   = 2;
  localparam int EXP_HOLD_CS_HIGH = 0;
`else
  localparam int EXP_HOLD_DONES   = 1;
  localparam int EXP_HOLD_CS_HIGH = 130;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start from IDLE and observes 140 cycles; sample k=1 follows the accepting edge.
  task automatic run_frame(input logic [31:0] data, output int rises, output int cs_low,
                           output int dones, output int gap, output int ones);
    int   done_k;
    logic prev_sck;
    rises = 0; cs_low = 0; dones = 0; gap = -1; ones = 0; done_k = -1; prev_sck = 1'b0;
    tx_data = data;
    start   = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (!cs_n) cs_low++;
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
      if (mosi) ones++;
      if (done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && gap < 0 && !busy) gap = k - done_k;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   rises, cs_low, dones, gap, ones;

    vecs[0] = '{32'hA5A50003, 2'd0, 32'hA5A50003, 44};
    vecs[1] = '{32'h00000000, 2'd1, 32'hFFFFFFFF, 0};
    vecs[2] = '{32'h00000000, 2'd2, 32'h00000000, 0};
    vecs[3] = '{32'hFFFFFFFF, 2'd2, 32'h00000000, 132};
    vecs[4] = '{32'h80000001, 2'd0, 32'h80000001, 12};
    vecs[5] = '{32'h12345678, 2'd0, 32'h12345678, 52};

    rst = 1'b1; start = 1'b0; tx_data = '0; miso_mode = 2'd0; start8 = 1'b0; tx8 = '0;
    slave_rx = '0;
    repeat (3) tick();
    check("rst_cs_n", cs_n, 1); check("rst_sck", sck, 0); check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_rx", rx_data, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      miso_mode = vecs[i].mode;
      run_frame(vecs[i].tx, rises, cs_low, dones, gap, ones);
      check($sformatf("v%0d_rx", i), rx_data, vecs[i].rx);
      check($sformatf("v%0d_rises", i), rises, 32);
      check($sformatf("v%0d_cs_low", i), cs_low, 132);
      check($sformatf("v%0d_dones", i), dones, 1);
      check($sformatf("v%0d_busy_gap", i), gap, 2);
      check($sformatf("v%0d_mosi_ones", i), ones, vecs[i].ones);
      repeat (2) tick();
    end

    // Reset on SCK rise #10 aborts the frame on the very next edge.
    begin
      logic prev_sck;
      miso_mode = 2'd0;
      rises = 0; prev_sck = 1'b0;
      tx_data = 32'hA5A50003;
      start = 1'b1;
      for (int k = 1; k <= 200 && rises < 10; k++) begin
        tick();
        if (k == 1) start = 1'b0;
        if (sck && !prev_sck) rises++;
        prev_sck = sck;
      end
      check("abort_reached_rise10", rises, 10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_cs_n", cs_n, 1); check("abort_sck", sck, 0); check("abort_mosi", mosi, 0);
      check("abort_busy", busy, 0); check("abort_done", done, 0); check("abort_rx", rx_data, 0);
      tick();
      run_frame(32'h5A5A0F0F, rises, cs_low, dones, gap, ones);
      check("post_abort_rx", rx_data, 32'h5A5A0F0F);
      check("post_abort_rises", rises, 32);
      check("post_abort_cs_low", cs_low, 132);
      check("post_abort_dones", dones, 1);
      repeat (2) tick();
    end

    // Start held high: one frame per IDLE entry, 3-cycle CS_N high gap (GAP + IDLE).
    begin
      logic prev_cs;
      int   falls, high_run, min_high;
      bit   seen_low;
      prev_cs = 1'b1; falls = 0; high_run = 0; min_high = 1000; seen_low = 0; dones = 0;
      tx_data = 32'h0F0F0F0F;
      start = 1'b1;
      for (int k = 1; k <= 405; k++) begin
        tick();
        if (done) dones++;
        if (!cs_n && prev_cs) begin
          falls++;
          if (seen_low && high_run < min_high) min_high = high_run;
        end
        if (cs_n) high_run++;
        else begin
          high_run = 0;
          seen_low = 1;
        end
        prev_cs = cs_n;
      end
      start = 1'b0;
      repeat (5) tick();
      check("held_dones", dones, 3);
      check("held_frames", falls, 3);
      check("held_min_cs_high", min_high, 3);
      check("held_idle_busy", busy, 0);
      check("held_rx", rx_data, 32'h0F0F0F0F);
    end

    // Start in the last HOLD cycle: chained word with burst, ignored otherwise.
    begin
      int          done1_k, done2_k, cs_high;
      logic [31:0] rx1, rx2;
      logic        busy_265;
      done1_k = -1; done2_k = -1; cs_high = 0; dones = 0; rx1 = '0; rx2 = '0; busy_265 = 1'b1;
      tx_data = 32'h11111111;
      start = 1'b1;
      for (int k = 1; k <= 300; k++) begin
        tick();
        if (k == 1) start = 1'b0;
        if (k == 132) begin
          start   = 1'b1;
          tx_data = 32'h22222222;
        end
        if (k == 133) start = 1'b0;
        if (k <= 262 && cs_n) cs_high++;
        if (k == 265) busy_265 = busy;
        if (done) begin
          dones++;
          if (done1_k < 0) begin
            done1_k = k; rx1 = rx_data;
          end else if (done2_k < 0) begin
            done2_k = k; rx2 = rx_data;
          end
        end
      end
      check("hold_dones", dones, EXP_HOLD_DONES);
      check("hold_cs_high", cs_high, EXP_HOLD_CS_HIGH);
      check("hold_done1_k", done1_k, 133);
      check("hold_rx1", rx1, 32'h11111111);
      check("hold_busy_after", busy_265, 0);
`ifdef SPI_MASTER_BURST_EN
      check("burst_done_spacing", done2_k - done1_k, 130);
      check("burst_rx2", rx2, 32'h22222222);
`endif
    end

    // DIV=1, 8-bit frame against the slave model.
    begin
      logic prev_sck;
      int   r1, r2;
      prev_sck = 1'b0; rises = 0; cs_low = 0; dones = 0; r1 = -1; r2 = -1;
      tx8 = 8'hC3;
      start8 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (k == 1) begin
          start8 = 1'b0;
          check("d8_busy_start", busy8, 1);
        end
        if (!cs8) cs_low++;
        if (sck8 && !prev_sck) begin
          rises++;
          if (r1 < 0) r1 = k;
          else if (r2 < 0) r2 = k;
        end
        prev_sck = sck8;
        if (done8) dones++;
      end
      check("d8_rises", rises, 8);
      check("d8_sck_period", r2 - r1, 2);
      check("d8_cs_low", cs_low, 19);
      check("d8_dones", dones, 1);
      check("d8_rx", rx8, 8'h3C);
      check("d8_slave_rx", slave_rx, 8'hC3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
